rca_32: RTL and testbench

RCA_32 -- requirements
Module: rca_32

---
 rtl/rca_32_if.sv | 30 +++
 rtl/rca_32.sv | 111 +++++++++++
 tb/tb_rca_32.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rca_32_if.sv
// rca_32_if -- operand/result/power-status bundle for the 32-bit power-gated adder.
//   A, B      : 32-bit addends
//   C_in      : carry-in to bit 0
//   flag      : 1 = request upper-half power-down, 0 = request power-up
//   S_out     : registered 32-bit sum
//   C_out     : registered carry-out of bit 31
//   iso_en    : isolation enable status
//   ret_en    : retention enable status
//   pse       : power-switch enable (1 = upper half powered)
interface rca_32_if;
   logic [31:0] A;
   logic [31:0] B;
   logic        C_in;
   logic        flag;
   logic [31:0] S_out;
   logic        C_out;
   logic        iso_en;
   logic        ret_en;
   logic        pse;

   modport master (
      output A, B, C_in, flag,
      input  S_out, C_out, iso_en, ret_en, pse
   );

   modport slave (
      input  A, B, C_in, flag,
      output S_out, C_out, iso_en, ret_en, pse
   );
endinterface

// File: rtl/rca_32.sv
// rca_32 -- 32-bit ripple-carry adder split into an always-on lower half (bits 15:0) and a
// power-gated upper half (bits 31:16 plus carry-out), with a power-control sequencer.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : rca_32_if slave (operands, flag in; registered sum, carry, power status out)
module rca_32 (
   input logic   clk,
   input logic   rst_n,
   rca_32_if.slave bus
);

   typedef enum logic [2:0] {
      StOn,
      StIso,
      StSave,
      StOff,
      StWake,
      StRestore
   } pwr_state_e;

   pwr_state_e  state_q, state_d;
   logic        iso_q, ret_en_q, pse_q;

   logic [15:0] lo_q;
   logic [16:0] hi_q;   // {carry-out, sum[31:16]}
   logic [16:0] ret_q;  // retention copy of hi_q

   logic [16:0] lo_sum;
   logic [16:0] hi_sum;

   // Lower carry ripples straight into the upper half within the same cycle.
   always_comb begin
      lo_sum = {1'b0, bus.A[15:0]} + {1'b0, bus.B[15:0]} + {16'b0, bus.C_in};
      hi_sum = {1'b0, bus.A[31:16]} + {1'b0, bus.B[31:16]} + {16'b0, lo_sum[16]};
   end

   // Power status code {iso_en, ret_en, pse} for each state.
   function automatic logic [2:0] pwr_code(input pwr_state_e st);
      logic [2:0] code;
      code = 3'b001;
      case (st)
         StOn:      code = 3'b001;
         StIso:     code = 3'b101;
         StSave:    code = 3'b111;
         StOff:     code = 3'b110;
         StWake:    code = 3'b111;
         StRestore: code = 3'b101;
         default:   code = 3'b001;
      endcase
      return code;
   endfunction

   // flag is only looked at in ON and OFF; the other states step unconditionally.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StOn:      if (bus.flag)  state_d = StIso;
         StIso:     state_d = StSave;
         StSave:    state_d = StOff;
         StOff:     if (!bus.flag) state_d = StWake;
         StWake:    state_d = StRestore;
         StRestore: state_d = StOn;
         default:   state_d = StOn;
      endcase
   end

   // Status outputs are registered alongside the state so they track it exactly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StOn;
         iso_q    <= 1'b0;
         ret_en_q <= 1'b0;
         pse_q    <= 1'b1;
      end else begin
         state_q                     <= state_d;
         {iso_q, ret_en_q, pse_q}    <= pwr_code(state_d);
      end
   end

   // Upper-half register: adds only in ON. Leaving SAVE it is captured into retention and
   // cleared, so it reads 0 for all of OFF/WAKE; leaving WAKE and during RESTORE it is
   // reloaded from retention, so RESTORE and the first ON cycle show the saved value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lo_q  <= 16'h0;
         hi_q  <= 17'h0;
         ret_q <= 17'h0;
      end else begin
         lo_q <= lo_sum[15:0];
         case (state_q)
            StOn:      hi_q <= hi_sum;
            StIso:     hi_q <= hi_q;
            StSave: begin
               ret_q <= hi_q;
               hi_q  <= 17'h0;
            end
            StOff:     hi_q <= 17'h0;
            StWake:    hi_q <= ret_q;
            StRestore: hi_q <= ret_q;
            default:   hi_q <= hi_q;
         endcase
      end
   end

   assign bus.S_out  = {hi_q[15:0], lo_q};
   assign bus.C_out  = hi_q[16];
   assign bus.iso_en = iso_q;
   assign bus.ret_en = ret_en_q;
   assign bus.pse    = pse_q;

endmodule

// File: tb/tb_rca_32.sv
// tb_rca_32 -- directed, table-driven bench for rca_32 plus hand-written power sequences.
module tb_rca_32;

   logic clk;
   logic rst_n;

   rca_32_if bus ();

   rca_32 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] s;
      logic        c;
   } vec_t;

   vec_t vecs [8];

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] PwrOn      = 3'b001;
   localparam logic [2:0] PwrIso     = 3'b101;
   localparam logic [2:0] PwrSave    = 3'b111;
   localparam logic [2:0] PwrOff     = 3'b110;
   localparam logic [2:0] PwrWake    = 3'b111;
   localparam logic [2:0] PwrRestore = 3'b101;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_pwr(input string name, input logic [2:0] exp);
      chk(name, {30'b0, bus.iso_en, bus.ret_en, bus.pse}, {30'b0, exp});
   endtask

   // Upper half incl. carry: {C_out, S_out[31:16]}
   task automatic chk_hi(input string name, input logic [16:0] exp);
      chk(name, {16'b0, bus.C_out, bus.S_out[31:16]}, {16'b0, exp});
   endtask

   task automatic chk_sum(input string name, input logic c, input logic [31:0] s);
      chk(name, {bus.C_out, bus.S_out}, {c, s});
   endtask

   // One rising edge, then settle away from it before sampling or driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic cin);
      bus.A    = a;
      bus.B    = b;
      bus.C_in = cin;
   endtask

   initial begin
      vecs[0] = '{a: 32'hFFFFFFFF, b: 32'h80000000, cin: 1'b0, s: 32'h7FFFFFFF, c: 1'b1};
      vecs[1] = '{a: 32'h0000FFFF, b: 32'h00000001, cin: 1'b0, s: 32'h00010000, c: 1'b0};
      vecs[2] = '{a: 32'h00000000, b: 32'h00000000, cin: 1'b1, s: 32'h00000001, c: 1'b0};
      vecs[3] = '{a: 32'hFFFFFFFF, b: 32'h00000000, cin: 1'b1, s: 32'h00000000, c: 1'b1};
      vecs[4] = '{a: 32'h12345678, b: 32'h87654321, cin: 1'b0, s: 32'h99999999, c: 1'b0};
      vecs[5] = '{a: 32'h0000FFFF, b: 32'h0000FFFF, cin: 1'b1, s: 32'h0001FFFF, c: 1'b0};
      vecs[6] = '{a: 32'h80000000, b: 32'h80000000, cin: 1'b0, s: 32'h00000000, c: 1'b1};
      vecs[7] = '{a: 32'h7FFFFFFF, b: 32'h00000001, cin: 1'b0, s: 32'h80000000, c: 1'b0};

      rst_n    = 1'b0;
      bus.flag = 1'b0;
      set_ops(32'h1234_5678, 32'h1111_1111, 1'b1);
      step();
      step();
      chk_sum("reset_sum", 1'b0, 32'h0);
      chk_pwr("reset_pwr", PwrOn);
      rst_n = 1'b1;
      set_ops(32'h0, 32'h0, 1'b0);
      step();

      // Plain adds in ON
      for (int i = 0; i < 8; i++) begin
         set_ops(vecs[i].a, vecs[i].b, vecs[i].cin);
         step();
         chk_sum($sformatf("add_vec%0d", i), vecs[i].c, vecs[i].s);
      end

      // Full power-down / power-up with flag held 6 cycles
      set_ops(32'hFFFFFFFF, 32'h80000000, 1'b0);
      step();
      chk_sum("pre_down_sum", 1'b1, 32'h7FFFFFFF);
      bus.flag = 1'b1;
      step();
      chk_pwr("seq_iso_pwr", PwrIso);
      chk_hi("seq_iso_hi", {1'b1, 16'h7FFF});
      set_ops(32'h00000001, 32'h00000001, 1'b0);  // upper half must ignore this
      step();
      chk_pwr("seq_save_pwr", PwrSave);
      chk_hi("seq_save_hi", {1'b1, 16'h7FFF});
      chk("seq_save_lo", {17'b0, bus.S_out[15:0]}, {17'b0, 16'h0002});
      step();
      chk_pwr("seq_off_pwr", PwrOff);
      chk_hi("seq_off_hi", 17'h0);
      chk("seq_off_lo", {17'b0, bus.S_out[15:0]}, {17'b0, 16'h0002});
      for (int i = 0; i < 3; i++) begin
         step();
         chk_pwr($sformatf("seq_off_hold%0d", i), PwrOff);
         chk_hi($sformatf("seq_off_hold_hi%0d", i), 17'h0);
      end
      bus.flag = 1'b0;
      step();
      chk_pwr("seq_wake_pwr", PwrWake);
      chk_hi("seq_wake_hi", 17'h0);
      step();
      chk_pwr("seq_restore_pwr", PwrRestore);
      chk_hi("seq_restore_hi", {1'b1, 16'h7FFF});
      step();
      chk_pwr("seq_on_pwr", PwrOn);
      chk_hi("seq_on_hi", {1'b1, 16'h7FFF});
      step();
      chk_sum("seq_resume_sum", 1'b0, 32'h00000002);

      // Single-cycle flag pulse still runs the whole sequence
      set_ops(32'hFFFFFFFF, 32'h80000000, 1'b0);
      step();
      bus.flag = 1'b1;
      step();
      chk_pwr("pulse_iso", PwrIso);
      bus.flag = 1'b0;
      step();
      chk_pwr("pulse_save", PwrSave);
      step();
      chk_pwr("pulse_off", PwrOff);
      step();
      chk_pwr("pulse_wake", PwrWake);
      step();
      chk_pwr("pulse_restore", PwrRestore);
      chk_hi("pulse_restore_hi", {1'b1, 16'h7FFF});
      step();
      chk_pwr("pulse_on", PwrOn);

      // Reset while OFF
      bus.flag = 1'b1;
      step();
      step();
      step();
      chk_pwr("rst_pre_off", PwrOff);
      rst_n = 1'b0;
      step();
      chk_pwr("rst_off_pwr", PwrOn);
      chk_sum("rst_off_sum", 1'b0, 32'h0);
      bus.flag = 1'b0;
      rst_n    = 1'b1;
      set_ops(32'h0000FFFF, 32'h00000001, 1'b0);
      step();
      chk_sum("post_rst_add", 1'b0, 32'h00010000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
